// File: rtl/dec_trigger_ctl_pkg.sv
// Shared trigger types, CSR addresses and mcontrol bit positions for the decode-side trigger block.
// Pure declarations: no latency and no backpressure.
package dec_trigger_ctl_pkg;

    localparam int NUM_TRIG = 4;

    localparam logic [11:0] CSR_TSELECT = 12'h7A0;
    localparam logic [11:0] CSR_TDATA1  = 12'h7A1;
    localparam logic [11:0] CSR_TDATA2  = 12'h7A2;

    localparam logic [3:0] TD1_TYPE    = 4'h2;
    localparam int         TD1_DMODE   = 27;
    localparam int         TD1_HIT     = 20;
    localparam int         TD1_SELECT  = 19;
    localparam int         TD1_ACTION  = 12;
    localparam int         TD1_CHAIN   = 11;
    localparam int         TD1_MATCH   = 7;
    localparam int         TD1_M       = 6;
    localparam int         TD1_EXECUTE = 2;
    localparam int         TD1_STORE   = 1;
    localparam int         TD1_LOAD    = 0;

    typedef struct packed {
        logic        select;
        logic        match;
        logic        store;
        logic        load;
        logic        execute;
        logic        m;
        logic [31:0] tdata2;
    } trigger_pkt_t;

    typedef struct packed {
        logic dmode;
        logic hit;
        logic select;
        logic action;
        logic chain;
        logic match;
        logic m;
        logic execute;
        logic store;
        logic load;
    } mcontrol_t;

    function automatic logic [31:0] mcontrol_rd(input mcontrol_t c);
        logic [31:0] r;
        r              = '0;
        r[31:28]       = TD1_TYPE;
        r[TD1_DMODE]   = c.dmode;
        r[TD1_HIT]     = c.hit;
        r[TD1_SELECT]  = c.select;
        r[TD1_ACTION]  = c.action;
        r[TD1_CHAIN]   = c.chain;
        r[TD1_MATCH]   = c.match;
        r[TD1_M]       = c.m;
        r[TD1_EXECUTE] = c.execute;
        r[TD1_STORE]   = c.store;
        r[TD1_LOAD]    = c.load;
        return r;
    endfunction

    // dmode only sticks from debug mode; chain only exists on the even trigger of a pair
    function automatic mcontrol_t mcontrol_wr(input logic [31:0] d, input logic dbg, input logic even);
        mcontrol_t c;
        c.dmode   = d[TD1_DMODE] & dbg;
        c.hit     = d[TD1_HIT];
        c.select  = d[TD1_SELECT];
        c.action  = d[TD1_ACTION];
        c.chain   = d[TD1_CHAIN] & even;
        c.match   = d[TD1_MATCH];
        c.m       = d[TD1_M];
        c.execute = d[TD1_EXECUTE];
        c.store   = d[TD1_STORE];
        c.load    = d[TD1_LOAD];
        return c;
    endfunction

endpackage

// File: rtl/dec_trigger_ctl_if.sv
// CSR access, raw match inputs and trigger packet/hit outputs of the trigger controller.
// Master drives CSR/match/flush, slave returns read data, packets and hits; no backpressure.
interface dec_trigger_ctl_if;
    import dec_trigger_ctl_pkg::*;

    logic                               csr_wr_en;
    logic [11:0]                        csr_wr_addr;
    logic [31:0]                        csr_wr_data;
    logic [11:0]                        csr_rd_addr;
    logic [31:0]                        csr_rd_data;
    logic                               csr_rd_hit;
    logic                               dbg_mode;
    logic [NUM_TRIG-1:0]                lsu_trigger_match_dc3;
    logic [NUM_TRIG-1:0]                ifu_trigger_match_dc3;
    logic                               flush_lower_wb;
    trigger_pkt_t [NUM_TRIG-1:0]        trigger_pkt_any;
    logic [NUM_TRIG-1:0]                trigger_hit_wb;
    logic                               trigger_action_dbg_wb;

    modport master (
        output csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_addr, dbg_mode,
               lsu_trigger_match_dc3, ifu_trigger_match_dc3, flush_lower_wb,
        input  csr_rd_data, csr_rd_hit, trigger_pkt_any, trigger_hit_wb, trigger_action_dbg_wb
    );

    modport slave (
        input  csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_addr, dbg_mode,
               lsu_trigger_match_dc3, ifu_trigger_match_dc3, flush_lower_wb,
        output csr_rd_data, csr_rd_hit, trigger_pkt_any, trigger_hit_wb, trigger_action_dbg_wb
    );

endinterface

// File: rtl/dec_trigger_pair_chain.sv
// Chaining for one even/odd trigger pair: when chained, both fire only if both matched.
// Latency: combinational; no backpressure.
module dec_trigger_pair_chain (
    input  logic       i_chain,
    input  logic [1:0] i_match,
    output logic [1:0] o_hit
);

    assign o_hit = i_chain ? {2{&i_match}} : i_match;

endmodule

// File: rtl/dec_trigger_ctl.sv
// Trigger CSRs (tselect/tdata1/tdata2) for 4 triggers plus dc3->wb match qualification.
// Latency: raw match to trigger_hit_wb is 2 cycles, CSR writes visible next cycle; no backpressure.
module dec_trigger_ctl
    import dec_trigger_ctl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    dec_trigger_ctl_if.slave  bus
);

    logic [1:0]          r_tselect;
    mcontrol_t           r_mctl   [NUM_TRIG];
    logic [31:0]         r_tdata2 [NUM_TRIG];
    logic [NUM_TRIG-1:0] r_dc4;
    logic [NUM_TRIG-1:0] r_wb;

    logic [NUM_TRIG-1:0] w_raw;
    logic [NUM_TRIG-1:0] w_kill;
    logic [NUM_TRIG-1:0] w_chain_hit;
    logic [NUM_TRIG-1:0] w_hit;
    logic [NUM_TRIG-1:0] w_action;
    logic                w_sel_locked;
    logic                w_wr_tsel;
    logic                w_wr_td1;
    logic                w_wr_td2;
    mcontrol_t           w_new_mctl;
    mcontrol_t           w_mctl_nxt [NUM_TRIG];
    logic [31:0]         w_rd_data;
    logic                w_rd_hit;

    assign w_raw  = bus.lsu_trigger_match_dc3 | bus.ifu_trigger_match_dc3;
    assign w_kill = {NUM_TRIG{bus.flush_lower_wb}};

    // A dmode trigger belongs to the debugger: outside debug mode its data CSRs are frozen
    assign w_sel_locked = r_mctl[r_tselect].dmode & ~bus.dbg_mode;
    assign w_wr_tsel    = bus.csr_wr_en && (bus.csr_wr_addr == CSR_TSELECT) && (bus.csr_wr_data[31:2] == '0);
    assign w_wr_td1     = bus.csr_wr_en && (bus.csr_wr_addr == CSR_TDATA1) && !w_sel_locked;
    assign w_wr_td2     = bus.csr_wr_en && (bus.csr_wr_addr == CSR_TDATA2) && !w_sel_locked;
    assign w_new_mctl   = mcontrol_wr(bus.csr_wr_data, bus.dbg_mode, ~r_tselect[0]);

    for (genvar p = 0; p < NUM_TRIG / 2; p++) begin : g_pair
        dec_trigger_pair_chain u_chain (
            .i_chain (r_mctl[2*p].chain),
            .i_match (r_wb[2*p+1 -: 2]),
            .o_hit   (w_chain_hit[2*p+1 -: 2])
        );
    end

    assign w_hit = w_chain_hit & ~w_kill;

    // Hardware hit set is ORed in after any software write so it cannot be lost
    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            w_mctl_nxt[i] = r_mctl[i];
            if (w_wr_td1 && (r_tselect == i[1:0])) begin
                w_mctl_nxt[i] = w_new_mctl;
            end
            w_mctl_nxt[i].hit = w_mctl_nxt[i].hit | w_hit[i];
            w_action[i]       = r_mctl[i].action;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tselect <= '0;
            r_dc4     <= '0;
            r_wb      <= '0;
            for (int i = 0; i < NUM_TRIG; i++) begin
                r_mctl[i]   <= '0;
                r_tdata2[i] <= '0;
            end
        end else begin
            if (w_wr_tsel) begin
                r_tselect <= bus.csr_wr_data[1:0];
            end
            r_dc4 <= w_raw & ~w_kill;
            r_wb  <= r_dc4 & ~w_kill;
            for (int i = 0; i < NUM_TRIG; i++) begin
                r_mctl[i] <= w_mctl_nxt[i];
                if (w_wr_td2 && (r_tselect == i[1:0])) begin
                    r_tdata2[i] <= bus.csr_wr_data;
                end
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_hit  = 1'b0;
        case (bus.csr_rd_addr)
            CSR_TSELECT: begin
                w_rd_hit  = 1'b1;
                w_rd_data = {30'b0, r_tselect};
            end
            CSR_TDATA1: begin
                w_rd_hit  = 1'b1;
                w_rd_data = mcontrol_rd(r_mctl[r_tselect]);
            end
            CSR_TDATA2: begin
                w_rd_hit  = 1'b1;
                w_rd_data = r_tdata2[r_tselect];
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_TRIG; i++) begin
            bus.trigger_pkt_any[i].select  = r_mctl[i].select  & r_mctl[i].m;
            bus.trigger_pkt_any[i].match   = r_mctl[i].match   & r_mctl[i].m;
            bus.trigger_pkt_any[i].store   = r_mctl[i].store   & r_mctl[i].m;
            bus.trigger_pkt_any[i].load    = r_mctl[i].load    & r_mctl[i].m;
            bus.trigger_pkt_any[i].execute = r_mctl[i].execute & r_mctl[i].m;
            bus.trigger_pkt_any[i].m       = r_mctl[i].m;
            bus.trigger_pkt_any[i].tdata2  = r_tdata2[i];
        end
    end

    assign bus.csr_rd_data           = w_rd_data;
    assign bus.csr_rd_hit            = w_rd_hit;
    assign bus.trigger_hit_wb        = w_hit;
    assign bus.trigger_action_dbg_wb = |(w_hit & w_action);

endmodule

// File: tb/tb_dec_trigger_ctl.sv
// Self-checking bench for dec_trigger_ctl: directed scenarios then random traffic against a CSR/history model.
module tb_dec_trigger_ctl;
    import dec_trigger_ctl_pkg::*;

    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dec_trigger_ctl_if bus();

    dec_trigger_ctl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: architectural CSR words plus a per-cycle history of raw matches and flushes
    logic [1:0]  m_tsel;
    logic [31:0] m_td1 [4];
    logic [31:0] m_td2 [4];
    logic [3:0]  raw_h [MAXC];
    logic        fl_h  [MAXC];
    int          cyc     = 0;
    int          rst_cyc = 0;
    logic [11:0] cur_ra  = CSR_TDATA1;

    function automatic logic [3:0] raw_at(input int c);
        if (c <= rst_cyc) return 4'h0;
        return raw_h[c];
    endfunction

    function automatic logic fl_at(input int c);
        if (c <= rst_cyc) return 1'b0;
        return fl_h[c];
    endfunction

    function automatic logic [3:0] model_hit();
        logic [3:0] x;
        logic [3:0] h;
        x = raw_at(cyc - 2);
        if (fl_at(cyc - 2) || fl_at(cyc - 1)) x = 4'h0;
        h = x;
        for (int e = 0; e < 4; e += 2) begin
            if (m_td1[e][TD1_CHAIN]) begin
                h[e]   = x[e] & x[e+1];
                h[e+1] = x[e] & x[e+1];
            end
        end
        if (fl_h[cyc]) h = 4'h0;
        return h;
    endfunction

    task automatic model_reset();
        m_tsel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            m_td1[i] = 32'h2000_0000;
            m_td2[i] = 32'h0;
        end
    endtask

    task automatic cycle(input logic r, input logic we, input logic [11:0] wa, input logic [31:0] wd,
                         input logic dbg, input logic [3:0] lsu, input logic [3:0] ifu, input logic fl);
        logic [3:0]   eh;
        logic [31:0]  erd;
        logic         erh;
        logic [31:0]  mask;
        trigger_pkt_t ep;
        logic         mm;
        rst                       = r;
        bus.csr_wr_en             = we;
        bus.csr_wr_addr           = wa;
        bus.csr_wr_data           = wd;
        bus.csr_rd_addr           = cur_ra;
        bus.dbg_mode              = dbg;
        bus.lsu_trigger_match_dc3 = lsu;
        bus.ifu_trigger_match_dc3 = ifu;
        bus.flush_lower_wb        = fl;
        #2;
        raw_h[cyc] = lsu | ifu;
        fl_h[cyc]  = fl;
        if (r) begin
            model_reset();
            rst_cyc = cyc;
            eh      = 4'h0;
        end else begin
            eh = model_hit();
        end
        erh = 1'b1;
        case (cur_ra)
            CSR_TSELECT: erd = {30'b0, m_tsel};
            CSR_TDATA1:  erd = m_td1[m_tsel];
            CSR_TDATA2:  erd = m_td2[m_tsel];
            default: begin erd = 32'h0; erh = 1'b0; end
        endcase
        chk("hit_wb", 64'(bus.trigger_hit_wb), 64'(eh));
        chk("action_dbg", 64'(bus.trigger_action_dbg_wb), 64'(|(eh & {m_td1[3][TD1_ACTION], m_td1[2][TD1_ACTION],
                                                                        m_td1[1][TD1_ACTION], m_td1[0][TD1_ACTION]})));
        chk("rd_data", 64'(bus.csr_rd_data), 64'(erd));
        chk("rd_hit", 64'(bus.csr_rd_hit), 64'(erh));
        for (int i = 0; i < 4; i++) begin
            mm         = m_td1[i][TD1_M];
            ep.select  = m_td1[i][TD1_SELECT] & mm;
            ep.match   = m_td1[i][TD1_MATCH] & mm;
            ep.store   = m_td1[i][TD1_STORE] & mm;
            ep.load    = m_td1[i][TD1_LOAD] & mm;
            ep.execute = m_td1[i][TD1_EXECUTE] & mm;
            ep.m       = mm;
            ep.tdata2  = m_td2[i];
            chk($sformatf("pkt%0d", i), 64'(bus.trigger_pkt_any[i]), 64'(ep));
        end
        @(posedge clk);
        if (!r) begin
            if (we) begin
                if (wa == CSR_TSELECT && wd < 32'd4) begin
                    m_tsel = wd[1:0];
                end else if (wa == CSR_TDATA1 && !(m_td1[m_tsel][TD1_DMODE] && !dbg)) begin
                    mask = 32'h0018_18C7;
                    if (dbg) mask[TD1_DMODE] = 1'b1;
                    if (m_tsel[0]) mask[TD1_CHAIN] = 1'b0;
                    m_td1[m_tsel] = 32'h2000_0000 | (wd & mask);
                end else if (wa == CSR_TDATA2 && !(m_td1[m_tsel][TD1_DMODE] && !dbg)) begin
                    m_td2[m_tsel] = wd;
                end
            end
            for (int i = 0; i < 4; i++) m_td1[i][TD1_HIT] = m_td1[i][TD1_HIT] | eh[i];
        end
        cyc++;
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic dbg);
        cycle(1'b0, 1'b1, a, d, dbg, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic match(input logic [3:0] lsu, input logic fl);
        cycle(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, lsu, 4'h0, fl);
    endtask

    initial begin
        logic [11:0] addrs [6];
        logic [11:0] a;
        logic [31:0] d;
        addrs[0] = CSR_TSELECT; addrs[1] = CSR_TDATA1; addrs[2] = CSR_TDATA2;
        addrs[3] = 12'h7A3;     addrs[4] = 12'h300;    addrs[5] = 12'h7A1;
        model_reset();

        cycle(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        cycle(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 4'hF, 4'h0, 1'b0);
        chk("rst_td1", 64'(bus.csr_rd_data), 64'h2000_0000);

        // Config trigger 2 as m/store with tdata2=0x1000
        wr(CSR_TSELECT, 32'd2, 1'b0);
        wr(CSR_TDATA1, 32'h2000_0042, 1'b0);
        wr(CSR_TDATA2, 32'h1000, 1'b0);
        idle();
        chk("pkt2_store", 64'(bus.trigger_pkt_any[2].store), 64'h1);
        chk("pkt2_tdata2", 64'(bus.trigger_pkt_any[2].tdata2), 64'h1000);
        chk("td1_rd", 64'(bus.csr_rd_data), 64'h2000_0042);

        cur_ra = CSR_TSELECT;
        wr(CSR_TSELECT, 32'd5, 1'b0);
        chk("tsel_ign", 64'(bus.csr_rd_data), 64'h2);

        // Single hit on trigger 2: pulse two cycles later, hit bit the cycle after
        cur_ra = CSR_TDATA1;
        match(4'b0100, 1'b0);
        chk("hit_n1", 64'(bus.trigger_hit_wb), 64'h0);
        idle();
        chk("hit_n2", 64'(bus.trigger_hit_wb), 64'h4);
        idle();
        chk("hit_n3", 64'(bus.trigger_hit_wb), 64'h0);
        chk("hitbit", 64'(bus.csr_rd_data), 64'h2010_0042);

        // Chain trigger pair 0/1
        wr(CSR_TSELECT, 32'd0, 1'b0);
        wr(CSR_TDATA1, 32'h0000_0840, 1'b0);
        match(4'b0001, 1'b0);
        idle();
        chk("chain_half", 64'(bus.trigger_hit_wb), 64'h0);
        idle();
        match(4'b0011, 1'b0);
        idle();
        chk("chain_both", 64'(bus.trigger_hit_wb), 64'h3);
        idle();

        // Flush one cycle after the raw match kills it
        wr(CSR_TSELECT, 32'd3, 1'b0);
        match(4'b1000, 1'b0);
        match(4'b0000, 1'b1);
        chk("flush_n2", 64'(bus.trigger_hit_wb), 64'h0);
        idle();
        idle();
        chk("flush_hitbit", 64'(bus.csr_rd_data), 64'h2000_0000);

        // dmode protection on trigger 1
        wr(CSR_TSELECT, 32'd1, 1'b1);
        wr(CSR_TDATA1, 32'h0800_0000, 1'b1);
        cur_ra = CSR_TDATA2;
        wr(CSR_TDATA2, 32'hFFFF, 1'b0);
        chk("dmode_lock", 64'(bus.csr_rd_data), 64'h0);
        wr(CSR_TDATA2, 32'hFFFF, 1'b1);
        chk("dmode_dbg", 64'(bus.csr_rd_data), 64'hFFFF);

        // Reset with matches in flight
        match(4'b1111, 1'b0);
        cycle(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 4'h0, 4'h0, 1'b0);
        idle();
        chk("rst_mid", 64'(bus.trigger_hit_wb), 64'h0);
        idle();

        for (int n = 0; n < 3000; n++) begin
            cur_ra = addrs[$urandom_range(0, 5)];
            a      = addrs[$urandom_range(0, 5)];
            d      = (a == CSR_TSELECT) ? 32'($urandom_range(0, 6)) : $urandom;
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), a, d,
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0,
                  ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0,
                  ($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
